receiver_uart: RTL

UART receive stage feeding the SoC memory-mapped IO read path. It is the counterpart to the existing transmit emitter and is driven from the board RX pin. It deserialises 8N1 frames into bytes and buffers them in a small first-word-fall-through FIFO. The CPU pops bytes through the IO data/control registers.

---
 rtl/receiver_uart.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/receiver_uart.sv
// 8N1 UART receiver with a small first-word-fall-through byte FIFO.
// Feeds the memory-mapped IO read path; CPU pops bytes via i_pop.
module receiver_uart #(
  parameter int clk_freq_hz = 12000000,
  parameter int baud_rate   = 115200,
  parameter int fifo_depth  = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          i_rx,
  input  logic                          i_pop,
  input  logic                          i_clr_err,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  output logic [$clog2(fifo_depth):0]   o_count,
  output logic                          o_overrun,
  output logic                          o_frame_err
);

  localparam int DIV  = clk_freq_hz / baud_rate;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam int PW   = $clog2(fifo_depth);
  localparam int NW   = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic          rx_s1;
  logic          rx_s2;
  logic          rx_d;
  logic [2:0]    warm;
  logic          fall;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [7:0]    sh;
  logic [7:0]    sh_n;
  logic          push;
  logic          ferr_set;

  logic [7:0]    mem [fifo_depth];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [NW-1:0] count;
  logic          full;
  logic          empty;
  logic          do_pop;
  logic          do_push;
  logic          ovr_set;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
      warm  <= '0;
    end else begin
      rx_s1 <= i_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      warm  <= {warm[1:0], 1'b1};
    end
  end

  // Only trust an edge once rx_d holds a real line sample, so a line
  // still low after reset release is never mistaken for a start bit.
  assign fall = warm[2] & rx_d & ~rx_s2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    sh_n     = sh;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fall) begin
          state_n = S_START;
          cnt_n   = '0;
        end
      end
      S_START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_n = '0;
          if (rx_s2) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_DATA;
            idx_n   = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == CW'(DIV - 1)) begin
          cnt_n = '0;
          sh_n  = {rx_s2, sh[7:1]};
          if (idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == CW'(DIV - 1)) begin
          cnt_n   = '0;
          state_n = S_IDLE;
          if (rx_s2) begin
            push = 1'b1;
          end else begin
            ferr_set = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign empty   = (count == '0);
  assign full    = (count == NW'(fifo_depth));
  assign do_pop  = i_pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovr_set = push & full & ~do_pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < fifo_depth; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= sh;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_overrun   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      if (ovr_set) begin
        o_overrun <= 1'b1;
      end else if (i_clr_err) begin
        o_overrun <= 1'b0;
      end
      if (ferr_set) begin
        o_frame_err <= 1'b1;
      end else if (i_clr_err) begin
        o_frame_err <= 1'b0;
      end
    end
  end

  assign o_valid = ~empty;
  assign o_data  = empty ? 8'h00 : mem[rd_ptr];
  assign o_count = count;

endmodule
